regfile_dump_ctrl: RTL and testbench
====================================

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 Port rst_i  input  1  asynchronous, active-high reset.
REQ-004 Port dump_req_i  input  1  request for a register-file snapshot, sampled each cycle.
REQ-005 Port cpu_rs1_addr_i  input  5  CPU read-port-1 address.
REQ-006 Port cpu_rs2_addr_i  input  5  CPU read-port-2 address.
REQ-007 Port rf_rs1_addr_o  output  5  register-file read-port-1 address (muxed).
REQ-008 Port rf_rs2_addr_o  output  5  register-file read-port-2 address (always cpu_rs2_addr_i).
REQ-009 Port rf_rs1_data_i  input  XLEN  register-file read-port-1 data, combinational read.
REQ-010 Port cpu_stall_o  output  1  freezes CPU PC and all CPU write enables while high.
REQ-011 Port dump_valid_o  output  1  dump beat valid.
REQ-012 Port dump_ready_i  input  1  dump beat accepted by sink.
REQ-013 Port dump_idx_o  output  5  register index of current beat.
REQ-014 Port dump_data_o  output  XLEN  register value of current beat.
REQ-015 Port dump_busy_o  output  1  high from leaving IDLE until return to IDLE.
REQ-016 Port dump_done_o  output  1  single-cycle pulse when snapshot completes.

Function
REQ-017 FSM states IDLE, FREEZE, READ, SEND, DONE, state register binary-encoded.
REQ-018 IDLE: dump_req_i=1 -> FREEZE, idx loaded with first index; else stay.
REQ-019 FREEZE: cpu_stall_o=1, one cycle for in-flight CPU write to retire, -> READ.
REQ-020 READ: rf_rs1_addr_o=idx; dump_data_o<=rf_rs1_data_i, dump_idx_o<=idx, dump_valid_o<=1; -> SEND.
REQ-021 SEND: dump_valid_o, dump_idx_o, dump_data_o held stable until dump_valid_o & dump_ready_i.
REQ-022 SEND handshake: dump_valid_o<=0; idx==31 -> DONE, else idx<=idx+1 -> READ.
REQ-023 DONE: dump_done_o=1 for exactly one cycle, cpu_stall_o=0, -> IDLE.
REQ-024 cpu_stall_o=1 in FREEZE, READ, SEND; 0 in IDLE and DONE.
REQ-025 rf_rs1_addr_o=cpu_rs1_addr_i in IDLE, FREEZE, DONE; idx otherwise.
REQ-026 dump_req_i while not IDLE ignored, not queued.
REQ-027 dump_req_i in DONE cycle ignored; new request accepted next IDLE cycle.
REQ-028 Minimum beat spacing two cycles (READ+SEND); full 32-beat dump with ready tied high = 66 cycles request-to-done.
REQ-029 idx 5-bit, never wraps; terminal compare at 31.
REQ-030 dump_ready_i while dump_valid_o=0 has no effect.

Reset
REQ-031 rst_i=1 forces IDLE immediately, independent of clk_i.
REQ-032 Reset values: cpu_stall_o=0, dump_valid_o=0, dump_busy_o=0, dump_done_o=0, dump_idx_o=0, dump_data_o=0, idx=0.
REQ-033 Reset mid-dump aborts without dump_done_o pulse; CPU released same cycle.

Configuration
REQ-034 Macro REGFILE_DUMP_SKIP_X0_EN defined: first index 1, 31 beats, dump_idx_o 1..31, 64 cycles request-to-done (ready high).
REQ-035 Macro undefined: first index 0, 32 beats, dump_idx_o 0..31.

Verification
REQ-036 Regs x1=5, x31=0xDEADBEEF, ready high, pulse dump_req_i -> 32 beats idx 0..31, beat1 data 5, beat31 0xDEADBEEF, done pulse cycle 66.
REQ-037 Ready toggled 1-of-3 cycles -> beats never lost/duplicated, data stable while valid & !ready, stall held throughout.
REQ-038 dump_req_i pulsed again at beat 10 -> ignored, exactly 32 beats, one done pulse.
REQ-039 rst_i at beat 7 -> stall, valid, busy low before next clock edge; no done pulse; new request restarts at idx 0.
REQ-040 REGFILE_DUMP_SKIP_X0_EN defined, ready high -> 31 beats idx 1..31, done at cycle 64.
REQ-041 IDLE, cpu_rs1_addr_i=12 -> rf_rs1_addr_o=12 combinationally, cpu_stall_o=0.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// Register-file snapshot controller: stalls the CPU and streams x0..x31 out.
// REGFILE_DUMP_SKIP_X0_EN starts the walk at x1 (31 beats instead of 32).
module regfile_dump_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dump_req_i,
  input  logic [4:0]      cpu_rs1_addr_i,
  input  logic [4:0]      cpu_rs2_addr_i,
  output logic [4:0]      rf_rs1_addr_o,
  output logic [4:0]      rf_rs2_addr_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  output logic            cpu_stall_o,
  output logic            dump_valid_o,
  input  logic            dump_ready_i,
  output logic [4:0]      dump_idx_o,
  output logic [XLEN-1:0] dump_data_o,
  output logic            dump_busy_o,
  output logic            dump_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam logic [4:0] FIRST_IDX = 5'd1;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

  state_t     state;
  logic [4:0] idx;

  // The dump owns read port 1 only while it is actually walking registers.
  assign rf_rs1_addr_o = (state == S_READ || state == S_SEND)
                       ? idx : cpu_rs1_addr_i;
  assign rf_rs2_addr_o = cpu_rs2_addr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      idx          <= 5'd0;
      cpu_stall_o  <= 1'b0;
      dump_valid_o <= 1'b0;
      dump_idx_o   <= 5'd0;
      dump_data_o  <= '0;
      dump_busy_o  <= 1'b0;
      dump_done_o  <= 1'b0;
    end else begin
      dump_done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (dump_req_i) begin
            state       <= S_FREEZE;
            idx         <= FIRST_IDX;
            cpu_stall_o <= 1'b1;
            dump_busy_o <= 1'b1;
          end
        end
        S_FREEZE: begin
          state <= S_READ;
        end
        S_READ: begin
          dump_data_o  <= rf_rs1_data_i;
          dump_idx_o   <= idx;
          dump_valid_o <= 1'b1;
          state        <= S_SEND;
        end
        S_SEND: begin
          if (dump_valid_o && dump_ready_i) begin
            dump_valid_o <= 1'b0;
            if (idx == 5'd31) begin
              state       <= S_DONE;
              dump_done_o <= 1'b1;
              cpu_stall_o <= 1'b0;
            end else begin
              idx   <= idx + 5'd1;
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          dump_busy_o <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural register file.
// Outputs sampled on the falling edge; inputs driven there as well.
module tb_regfile_dump_ctrl;
  localparam int XLEN = 32;
`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
  localparam int NBEATS = 31;
  localparam int DONE_CYC = 64;
`else
  localparam int FIRST = 0;
  localparam int NBEATS = 32;
  localparam int DONE_CYC = 66;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            dump_req;
  logic [4:0]      cpu_rs1_addr;
  logic [4:0]      cpu_rs2_addr;
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data;
  logic            cpu_stall;
  logic            dump_valid;
  logic            dump_ready;
  logic [4:0]      dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_busy;
  logic            dump_done;

  logic [XLEN-1:0] rf [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rf_rs1_data = rf[rf_rs1_addr];

  regfile_dump_ctrl #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dump_req_i     (dump_req),
    .cpu_rs1_addr_i (cpu_rs1_addr),
    .cpu_rs2_addr_i (cpu_rs2_addr),
    .rf_rs1_addr_o  (rf_rs1_addr),
    .rf_rs2_addr_o  (rf_rs2_addr),
    .rf_rs1_data_i  (rf_rs1_data),
    .cpu_stall_o    (cpu_stall),
    .dump_valid_o   (dump_valid),
    .dump_ready_i   (dump_ready),
    .dump_idx_o     (dump_idx),
    .dump_data_o    (dump_data),
    .dump_busy_o    (dump_busy),
    .dump_done_o    (dump_done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready tied high, mode 1: ready high one cycle in three
  task automatic run_dump(input int mode, input int rereq_beat,
                          input int rst_beat, input string nm);
    int cyc = 0;
    int beats = 0;
    int dones = 0;
    int done_cyc = 0;
    bit bad_idx = 0, bad_data = 0, bad_stall = 0, bad_hold = 0;
    bit holding = 0, rereq_done = 0, finished = 0, aborted = 0;
    logic [XLEN-1:0] hold_d = '0, d1 = '0, d31 = '0;
    logic [4:0] hold_i = '0;
    @(negedge clk);
    dump_req = 1'b1;
    dump_ready = (mode == 0);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    for (int t = 0; t < 400; t++) begin
      dump_req = 1'b0;
      if (dump_done) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (!dump_busy) begin
        finished = 1;
        break;
      end
      if (!dump_done && !cpu_stall) bad_stall = 1;
      if (holding && (!dump_valid || dump_data !== hold_d
                      || dump_idx !== hold_i))
        bad_hold = 1;
      if (rst_beat >= 0 && beats == rst_beat && dump_valid) begin
        rst = 1'b1;
        #1;
        chk({nm, "_rst_stall"}, 64'(cpu_stall), 64'd0);
        chk({nm, "_rst_valid"}, 64'(dump_valid), 64'd0);
        chk({nm, "_rst_busy"}, 64'(dump_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (rereq_beat >= 0 && beats == rereq_beat && dump_valid
          && !rereq_done) begin
        dump_req = 1'b1;
        rereq_done = 1;
      end
      if (mode == 1) dump_ready = (cyc % 3 == 0);
      holding = dump_valid && !dump_ready;
      hold_d = dump_data;
      hold_i = dump_idx;
      if (dump_valid && dump_ready) begin
        if (dump_idx !== 5'(FIRST + beats)) bad_idx = 1;
        if (dump_data !== rf[FIRST + beats]) bad_data = 1;
        if (dump_idx == 5'd1) d1 = dump_data;
        if (dump_idx == 5'd31) d31 = dump_data;
        beats++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    dump_req = 1'b0;
    if (aborted) begin
      chk({nm, "_no_done"}, 64'(dones), 64'd0);
      chk({nm, "_post_idx"}, 64'(dump_idx), 64'd0);
      chk({nm, "_post_data"}, 64'(dump_data), 64'd0);
    end else begin
      chk({nm, "_finished"}, 64'(finished), 64'd1);
      chk({nm, "_beats"}, 64'(beats), 64'(NBEATS));
      chk({nm, "_dones"}, 64'(dones), 64'd1);
      chk({nm, "_bad_idx"}, 64'(bad_idx), 64'd0);
      chk({nm, "_bad_data"}, 64'(bad_data), 64'd0);
      chk({nm, "_x1"}, 64'(d1), 64'd5);
      chk({nm, "_x31"}, 64'(d31), 64'hDEADBEEF);
      chk({nm, "_stall_held"}, 64'(bad_stall), 64'd0);
      if (mode == 0)
        chk({nm, "_done_cyc"}, 64'(done_cyc), 64'(DONE_CYC));
      else
        chk({nm, "_hold"}, 64'(bad_hold), 64'd0);
    end
    chk({nm, "_idle_stall"}, 64'(cpu_stall), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rf[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    rf[0] = '0;
    rf[1] = 32'd5;
    rf[31] = 32'hDEADBEEF;
    rst = 1'b1;
    dump_req = 1'b0;
    dump_ready = 1'b0;
    cpu_rs1_addr = 5'd0;
    cpu_rs2_addr = 5'd0;
    #1;
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_valid", 64'(dump_valid), 64'd0);
    chk("rst_busy", 64'(dump_busy), 64'd0);
    chk("rst_done", 64'(dump_done), 64'd0);
    chk("rst_idx", 64'(dump_idx), 64'd0);
    chk("rst_data", 64'(dump_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_rs1_addr = 5'd12;
    cpu_rs2_addr = 5'd9;
    #1;
    chk("idle_rs1_mux", 64'(rf_rs1_addr), 64'd12);
    chk("idle_rs2", 64'(rf_rs2_addr), 64'd9);
    chk("idle_stall", 64'(cpu_stall), 64'd0);
    run_dump(0, -1, -1, "ready_hi");
    run_dump(1, -1, -1, "ready_1of3");
    run_dump(0, 10, -1, "rereq");
    run_dump(0, -1, 7, "rst7");
    run_dump(0, -1, -1, "restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
